// File: rtl/aes_block_packer.sv
// aes_block_packer
// Packs a stream of IN_WIDTH-bit words into OUT_WIDTH-bit blocks for the
// AES engine. One block is assembled while the previously completed block
// waits in the output register, so the input side keeps taking one word per
// cycle as long as the engine keeps taking blocks. A word flagged with
// in_last_i closes a partial block; the unused upper slots read as zero.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   clear_i                 synchronous soft clear (same effect as reset)
//   enable_i                0 freezes the input side; output still drains
//   in_data_i/in_valid_i/in_ready_o/in_last_i   word stream in
//   out_data_o/out_valid_o/out_ready_i          block stream out
//   out_nwords_o            real words in the block (1..N)
//   out_last_o              block holds the job's last word
//   blk_cnt_o               blocks handed off since reset/clear (wraps)
//   busy_o                  partial block in assembly or block pending
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. valid never waits on ready; in_ready_o never depends on in_valid_i.
// While out_valid_o is high and out_ready_i is low the output fields hold.
module aes_block_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 128,
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_WIDTH  = 16,
  localparam int N         = OUT_WIDTH / IN_WIDTH,
  localparam int NW_W      = $clog2(N) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_last_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NW_W-1:0]      out_nwords_o,
  output logic                 out_last_o,
  output logic [CNT_WIDTH-1:0] blk_cnt_o,
  output logic                 busy_o
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Bit offset of word slot k inside a block.
  function automatic int slot_base(input int k);
    return ((BIG_ENDIAN != 0) ? (N - 1 - k) : k) * IN_WIDTH;
  endfunction

  logic [OUT_WIDTH-1:0] asm_q;
  logic [IDX_W-1:0]     idx_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic [NW_W-1:0]      out_nwords_q;
  logic                 out_last_q;
  logic                 out_valid_q;
  logic [CNT_WIDTH-1:0] blk_cnt_q;

  logic                 out_free;
  logic                 idx_last;
  logic                 in_ready;
  logic                 accept;
  logic                 complete;
  logic                 out_hs;
  logic [OUT_WIDTH-1:0] asm_next;
  logic [OUT_WIDTH-1:0] blk_next;

  always_comb begin
    out_free = !out_valid_q | out_ready_i;
    idx_last = (idx_q == IDX_W'(N - 1));
    // A word that will not complete a block only needs room in asm_q,
    // which is always available; completing words need the output register.
    in_ready = enable_i & (out_free | (!idx_last & !in_last_i));
    accept   = in_valid_i & in_ready;
    complete = accept & (idx_last | in_last_i);
    out_hs   = out_valid_q & out_ready_i;

    asm_next = asm_q;
    blk_next = '0;
    for (int k = 0; k < N; k++) begin
      if (k == int'(idx_q)) begin
        asm_next[slot_base(k) +: IN_WIDTH] = in_data_i;
        blk_next[slot_base(k) +: IN_WIDTH] = in_data_i;
      end else if (k < int'(idx_q)) begin
        blk_next[slot_base(k) +: IN_WIDTH] = asm_q[slot_base(k) +: IN_WIDTH];
      end
      // Slots above idx_q stay zero: that is the padding of a partial block.
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      asm_q        <= '0;
      idx_q        <= '0;
      out_data_q   <= '0;
      out_nwords_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      if (complete) begin
        // Also covers the back-to-back case where the old block leaves on
        // this same edge: the new one simply overwrites it.
        asm_q        <= '0;
        idx_q        <= '0;
        out_data_q   <= blk_next;
        out_nwords_q <= NW_W'(idx_q) + NW_W'(1);
        out_last_q   <= in_last_i;
        out_valid_q  <= 1'b1;
      end else begin
        if (accept) begin
          asm_q <= asm_next;
          idx_q <= idx_q + 1'b1;
        end
        if (out_hs) begin
          out_valid_q <= 1'b0;
        end
      end
      if (out_hs) begin
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  assign in_ready_o   = in_ready;
  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_nwords_o = out_nwords_q;
  assign out_last_o   = out_last_q;
  assign blk_cnt_o    = blk_cnt_q;
  assign busy_o       = (idx_q != '0) | out_valid_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer. Three instances share one input stream:
// default parameters, BIG_ENDIAN=1, and CNT_WIDTH=4. A behavioural model
// (word queue + expected-block queue) is advanced every cycle by a
// scoreboard process; scenario tasks add directed checks of their own.
module tb_aes_block_packer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         enable = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready, in_ready_be, in_ready_c4;
  logic [127:0] out_data, out_data_be, out_data_c4;
  logic         out_valid, out_valid_be, out_valid_c4;
  logic [2:0]   out_nwords, out_nwords_be, out_nwords_c4;
  logic         out_last, out_last_be, out_last_c4;
  logic [15:0]  blk_cnt, blk_cnt_be;
  logic [3:0]   blk_cnt_c4;
  logic         busy, busy_be, busy_c4;

  int n_tests = 0;
  int n_fail  = 0;

  aes_block_packer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_last_i(in_last), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_nwords_o(out_nwords), .out_last_o(out_last),
    .blk_cnt_o(blk_cnt), .busy_o(busy)
  );

  aes_block_packer #(.BIG_ENDIAN(1)) dut_be (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_be),
    .in_last_i(in_last), .out_data_o(out_data_be), .out_valid_o(out_valid_be),
    .out_ready_i(out_ready), .out_nwords_o(out_nwords_be), .out_last_o(out_last_be),
    .blk_cnt_o(blk_cnt_be), .busy_o(busy_be)
  );

  aes_block_packer #(.CNT_WIDTH(4)) dut_c4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_c4),
    .in_last_i(in_last), .out_data_o(out_data_c4), .out_valid_o(out_valid_c4),
    .out_ready_i(out_ready), .out_nwords_o(out_nwords_c4), .out_last_o(out_last_c4),
    .blk_cnt_o(blk_cnt_c4), .busy_o(busy_c4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]  words[$];
  logic [127:0] exp_q[$];
  bit           m_valid = 0;
  int           m_nwords = 0;
  bit           m_last = 0;
  int           m_cnt = 0;

  function automatic logic [127:0] to_be(input logic [127:0] le);
    logic [127:0] r;
    for (int i = 0; i < N; i++) r[(N-1-i)*32 +: 32] = le[i*32 +: 32];
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_ready, acc, hs;
    logic [127:0] blk;
    if (rst || clear) begin
      words.delete(); exp_q.delete();
      m_valid = 0; m_nwords = 0; m_last = 0; m_cnt = 0;
    end else begin
      exp_ready = enable && (!m_valid || out_ready || (words.size() != N-1 && !in_last));
      n_tests++;
      if (in_ready !== exp_ready || in_ready_be !== exp_ready) begin
        n_fail++; $display("FAIL sb_in_ready got %b/%b want %b", in_ready, in_ready_be, exp_ready);
      end
      n_tests++;
      if (out_valid !== m_valid || out_valid_c4 !== m_valid) begin
        n_fail++; $display("FAIL sb_out_valid got %b/%b want %b", out_valid, out_valid_c4, m_valid);
      end
      n_tests++;
      if (busy !== (words.size() != 0 || m_valid)) begin
        n_fail++; $display("FAIL sb_busy got %b want %b", busy, (words.size() != 0 || m_valid));
      end
      n_tests++;
      if (blk_cnt !== 16'(m_cnt) || blk_cnt_c4 !== 4'(m_cnt)) begin
        n_fail++; $display("FAIL sb_blk_cnt got %0d/%0d want %0d/%0d", blk_cnt, blk_cnt_c4, 16'(m_cnt), 4'(m_cnt));
      end
      if (m_valid && exp_q.size() > 0) begin
        n_tests++;
        if (out_data !== exp_q[0] || out_data_be !== to_be(exp_q[0])) begin
          n_fail++; $display("FAIL sb_out_data got %h / be %h want %h", out_data, out_data_be, exp_q[0]);
        end
        n_tests++;
        if (out_nwords !== 3'(m_nwords) || out_last !== m_last) begin
          n_fail++; $display("FAIL sb_nwords_last got %0d,%b want %0d,%b", out_nwords, out_last, m_nwords, m_last);
        end
      end
      hs  = m_valid && out_ready;
      acc = in_valid && exp_ready;
      if (hs) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt++;
      end
      if (acc) words.push_back(in_data);
      if (acc && (words.size() == N || in_last)) begin
        blk = '0;
        foreach (words[i]) blk[i*32 +: 32] = words[i];
        exp_q.push_back(blk);
        m_valid = 1; m_nwords = words.size(); m_last = in_last;
        words.delete();
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); ok = in_ready;
      tick();
      if (ok) return;
    end
    n_tests++; n_fail++;
    $display("FAIL send_word_timeout word %h not accepted in 200 cycles", d);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_clear();
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hffff_ffff; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    idle(); out_ready = 1'b0; rst = 1'b0;
    tick();
    n_tests++;
    if (out_data !== '0 || out_nwords !== 3'd0 || out_last !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got data %h nw %0d last %b valid %b want all 0", out_data, out_nwords, out_last, out_valid);
    end
    n_tests++;
    if (blk_cnt !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_status got cnt %0d busy %b ready %b want 0 0 1", blk_cnt, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send_word(32'(i), i == 4);
    idle();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 128'h00000004_00000003_00000002_00000001 ||
        out_nwords !== 3'd4 || out_last !== 1'b1 || blk_cnt !== 16'd0) begin
      n_fail++; $display("FAIL basic_block got v %b %h nw %0d last %b cnt %0d want 1 00000004000000030000000200000001 4 1 0",
                         out_valid, out_data, out_nwords, out_last, blk_cnt);
    end
    tick();
    n_tests++;
    if (blk_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_handoff got cnt %0d valid %b want 1 0", blk_cnt, out_valid);
    end
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send_word(32'hA, 1'b0); send_word(32'hB, 1'b0); send_word(32'hC, 1'b1);
    idle();
    n_tests++;
    if (out_data !== 128'h00000000_0000000C_0000000B_0000000A || out_nwords !== 3'd3 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL partial_le got %h nw %0d last %b want 000000000000000c0000000b0000000a 3 1", out_data, out_nwords, out_last);
    end
    n_tests++;
    if (out_data_be !== 128'h0000000A_0000000B_0000000C_00000000 || out_nwords_be !== 3'd3) begin
      n_fail++; $display("FAIL partial_be got %h nw %0d want 0000000a0000000b0000000c00000000 3", out_data_be, out_nwords_be);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = blk_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_word(32'h10 + 32'(i), i == 7);
        idle();
      end
      begin
        for (int t = 0; t < 50 && out_valid !== 1'b1; t++) tick();
        repeat (6) tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_stall got ready %b valid %b want 0 1", in_ready, out_valid);
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) tick();
    n_tests++;
    if (blk_cnt !== 16'(c0 + 2) || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_count got cnt %0d busy %b want %0d 0", blk_cnt, busy, c0 + 2);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send_word(32'hDEAD0001, 1'b0); send_word(32'hDEAD0002, 1'b0);
    pulse_clear();
    n_tests++;
    if (busy !== 1'b0 || out_data !== '0 || blk_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clear_state got busy %b data %h cnt %0d want 0 0 0", busy, out_data, blk_cnt);
    end
    send_word(32'h11, 1'b0); send_word(32'h22, 1'b0); send_word(32'h33, 1'b0); send_word(32'h44, 1'b1);
    idle();
    n_tests++;
    if (out_data !== 128'h00000044_00000033_00000022_00000011 || out_nwords !== 3'd4) begin
      n_fail++; $display("FAIL clear_fresh got %h nw %0d want 00000044000000330000002200000011 4", out_data, out_nwords);
    end
    tick();
    n_tests++;
    if (blk_cnt !== 16'd1) begin
      n_fail++; $display("FAIL clear_cnt got %0d want 1", blk_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    pulse_clear();
    out_ready = 1'b1;
    for (int b = 1; b <= 17; b++) begin
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
      idle();
      tick();
      n_tests++;
      if (blk_cnt_c4 !== 4'(b % 16) || blk_cnt !== 16'(b)) begin
        n_fail++; $display("FAIL cnt_wrap after %0d blocks got %0d/%0d want %0d/%0d", b, blk_cnt_c4, blk_cnt, b % 16, b);
      end
    end
  endtask

  task automatic test_enable();
    int c0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h100 + 32'(i), 1'b0);
    send_word(32'h200, 1'b0);
    c0 = blk_cnt;
    enable = 1'b0; in_valid = 1'b1; in_data = 32'h201; in_last = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL enable_frozen got ready %b busy %b valid %b want 0 1 1", in_ready, busy, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || blk_cnt !== 16'(c0 + 1)) begin
      n_fail++; $display("FAIL enable_drain got valid %b ready %b cnt %0d want 0 0 %0d", out_valid, in_ready, blk_cnt, c0 + 1);
    end
    enable = 1'b1;
    send_word(32'h201, 1'b0); send_word(32'h202, 1'b1);
    idle();
    n_tests++;
    if (out_data !== 128'h00000000_00000202_00000201_00000200 || out_nwords !== 3'd3) begin
      n_fail++; $display("FAIL enable_resume got %h nw %0d want 00000000000002020000020100000200 3", out_data, out_nwords);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          send_word($urandom, (i == 119) || ($urandom_range(0, 4) == 0));
          if ($urandom_range(0, 2) == 0) begin
            idle();
            repeat ($urandom_range(1, 2)) tick();
          end
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
          enable    = ($urandom_range(0, 3) != 0);
        end
      end
    join
    enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain got busy %b pending %0d want 0 0", busy, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_clear();
    test_counter_wrap();
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
